// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared op-code constants and FSM state encoding for rf_sequencer
package rf_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;
    localparam logic [2:0] OP_SHR1 = 3'd6;
    localparam logic [2:0] OP_LDI  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_sequencer_if.sv
// rtl/rf_sequencer_if.sv - command handshake, register-file and status signals of rf_sequencer
interface rf_sequencer_if #(parameter int N = 8);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [2:0]   cmd_src1;
    logic [2:0]   cmd_src2;
    logic [2:0]   cmd_dst;
    logic [N-1:0] cmd_imm;

    logic [2:0]   addr1;
    logic [2:0]   addr2;
    logic [N-1:0] z1;
    logic [N-1:0] z2;
    logic [2:0]   addr3;
    logic [N-1:0] wr_data;
    logic         wr_en;

    logic         done;
    logic [N-1:0] result;
    logic         flag_z;
    logic         flag_c;

    // master: command issuer plus register file; slave: the sequencer
    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm, z1, z2,
        input  cmd_ready, addr1, addr2, addr3, wr_data, wr_en, done, result, flag_z, flag_c
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm, z1, z2,
        output cmd_ready, addr1, addr2, addr3, wr_data, wr_en, done, result, flag_z, flag_c
    );

endinterface

// File: rtl/rf_alu.sv
// rtl/rf_alu.sv - combinational ALU producing result and carry/borrow/shifted-out bit
module rf_alu
    import rf_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_imm,
    output logic [N-1:0] o_result,
    output logic         o_carry
);

    logic [N:0] w_sum;
    logic [N:0] w_diff;

    // one extra bit holds carry-out for ADD and the borrow for SUB
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[N-1:0];
                o_carry  = w_sum[N];
            end
            OP_SUB: begin
                o_result = w_diff[N-1:0];
                o_carry  = w_diff[N];
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SHL1: begin
                o_result = {i_a[N-2:0], 1'b0};
                o_carry  = i_a[N-1];
            end
            OP_SHR1: begin
                o_result = {1'b0, i_a[N-1:1]};
                o_carry  = i_a[0];
            end
            OP_LDI: o_result = i_imm;
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_regfile.sv
// rtl/rf_regfile.sv - 8-entry register file, two combinational read ports, one clocked write port
module rf_regfile #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic [2:0]   i_raddr1,
    input  logic [2:0]   i_raddr2,
    input  logic [2:0]   i_waddr,
    input  logic [N-1:0] i_wdata,
    input  logic         i_we,
    output logic [N-1:0] o_rdata1,
    output logic [N-1:0] o_rdata2
);

    logic [N-1:0] r_mem [8];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - four-state read/execute/write sequencer driving an external register file
module rf_sequencer
    import rf_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clock,
    input  logic          reset,
    rf_sequencer_if.slave bus
);

    state_e       r_state;
    state_e       w_next;
    logic [2:0]   r_op;
    logic [2:0]   r_src1;
    logic [2:0]   r_src2;
    logic [2:0]   r_dst;
    logic [N-1:0] r_imm;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_res;
    logic         r_res_c;
    logic [N-1:0] r_result;
    logic         r_flag_z;
    logic         r_flag_c;
    logic [N-1:0] w_alu_res;
    logic         w_alu_c;

    rf_alu #(.N(N)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu_res),
        .o_carry  (w_alu_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_dst    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_res_c  <= 1'b0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op   <= bus.cmd_op;
                        r_src1 <= bus.cmd_src1;
                        r_src2 <= bus.cmd_src2;
                        r_dst  <= bus.cmd_dst;
                        r_imm  <= bus.cmd_imm;
                    end
                end
                READ: begin
                    r_a <= bus.z1;
                    r_b <= bus.z2;
                end
                EXEC: begin
                    r_res   <= w_alu_res;
                    r_res_c <= w_alu_c;
                end
                WRITE: begin
                    r_result <= r_res;
                    r_flag_z <= (r_res == '0);
                    r_flag_c <= r_res_c;
                end
                default: ;
            endcase
        end
    end

    // write strobes are gated by reset so an abort in WRITE never reaches the register file
    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_next = READ;
                end
            end
            READ:  w_next = EXEC;
            EXEC:  w_next = WRITE;
            WRITE: begin
                bus.wr_en = !reset;
                bus.done  = !reset;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.addr1   = r_src1;
    assign bus.addr2   = r_src2;
    assign bus.addr3   = r_dst;
    assign bus.wr_data = r_res;
    assign bus.result  = r_result;
    assign bus.flag_z  = r_flag_z;
    assign bus.flag_c  = r_flag_c;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb/tb_rf_sequencer.sv - directed scoreboard bench for rf_sequencer with the 8-entry register file
module tb_rf_sequencer;
    import rf_pkg::*;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
        int         acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rf_sequencer_if #(.N(8)) bus ();

    rf_sequencer #(.N(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    rf_regfile #(.N(8)) u_rf (
        .clock    (clock),
        .i_raddr1 (bus.addr1),
        .i_raddr2 (bus.addr2),
        .i_waddr  (bus.addr3),
        .i_wdata  (bus.wr_data),
        .i_we     (bus.wr_en),
        .o_rdata1 (bus.z1),
        .o_rdata2 (bus.z2)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_acc = 0;
    logic       accepted_now = 1'b0;
    logic       no_expect = 1'b0;
    logic       pending = 1'b0;
    exp_t       pend;
    exp_t       sb [$];
    logic [7:0] mdl [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [2:0] op, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [2:0] dst,
                                     input logic [7:0] imm);
        exp_t       e;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] wide;
        a = mdl[s1];
        b = mdl[s2];
        e.c = 1'b0;
        e.data = 8'h00;
        case (op)
            OP_ADD:  begin wide = {1'b0, a} + {1'b0, b}; e.data = wide[7:0]; e.c = wide[8]; end
            OP_SUB:  begin e.data = a - b; e.c = (a < b); end
            OP_AND:  e.data = a & b;
            OP_OR:   e.data = a | b;
            OP_XOR:  e.data = a ^ b;
            OP_SHL1: begin e.data = a << 1; e.c = a[7]; end
            OP_SHR1: begin e.data = a >> 1; e.c = a[0]; end
            default: e.data = imm;
        endcase
        e.addr = dst;
        e.z = (e.data == 8'h00);
        e.acc = 0;
        return e;
    endfunction

    // one clock: detect acceptance, then monitor outputs at the following negedge
    task automatic step();
        logic acc;
        exp_t e;
        acc = bus.cmd_valid && bus.cmd_ready && !reset;
        e = predict(bus.cmd_op, bus.cmd_src1, bus.cmd_src2, bus.cmd_dst, bus.cmd_imm);
        @(posedge clock);
        @(negedge clock);
        cyc++;
        accepted_now = acc;
        if (acc) begin
            n_acc++;
            if (!no_expect) begin
                e.acc = cyc;
                sb.push_back(e);
                mdl[e.addr] = e.data;
            end
        end
        if (pending) begin
            chk("result", bus.result, pend.data);
            chk("flag_z", bus.flag_z, pend.z);
            chk("flag_c", bus.flag_c, pend.c);
            pending = 1'b0;
        end
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", bus.done, 1'b0);
            end else begin
                pend = sb.pop_front();
                chk("wr_en", bus.wr_en, 1'b1);
                chk("addr3", bus.addr3, pend.addr);
                chk("wr_data", bus.wr_data, pend.data);
                chk("latency", cyc + 1 - pend.acc, 3);
                pending = 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] dst, input logic [7:0] imm);
        bus.cmd_op = op;
        bus.cmd_src1 = s1;
        bus.cmd_src2 = s2;
        bus.cmd_dst = dst;
        bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        accepted_now = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (accepted_now) break;
        end
        if (!accepted_now) chk("accept_timeout", accepted_now, 1'b1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !pending) break;
            step();
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic check_idle_after_reset(input string tag);
        chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
        chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_result"}, bus.result, 8'h00);
        chk({tag, "_flag_z"}, bus.flag_z, 1'b0);
        chk({tag, "_flag_c"}, bus.flag_c, 1'b0);
        chk({tag, "_addr3"}, bus.addr3, 3'd0);
    endtask

    // phase 1 aborts in EXEC, phase 2 aborts with the DUT sitting in WRITE
    task automatic abort_in(input int phase, input string tag);
        no_expect = 1'b1;
        issue(OP_LDI, 3'd0, 3'd0, 3'd3, 8'h77);
        step();
        if (phase == 2) begin
            @(posedge clock);
            #1;
            reset = 1'b1;
            #1;
            chk({tag, "_wr_en_forced"}, bus.wr_en, 1'b0);
            chk({tag, "_done_forced"}, bus.done, 1'b0);
            @(negedge clock);
            cyc++;
        end else begin
            reset = 1'b1;
        end
        step();
        reset = 1'b0;
        no_expect = 1'b0;
        check_idle_after_reset(tag);
        chk({tag, "_r3_kept"}, u_rf.r_mem[3], mdl[3]);
        step();
        chk({tag, "_ready_next"}, bus.cmd_ready, 1'b1);
        step();
        step();
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_LDI;
        bus.cmd_src1 = 3'd0;
        bus.cmd_src2 = 3'd0;
        bus.cmd_dst = 3'd7;
        bus.cmd_imm = 8'hAA;

        // a command presented during reset must not be accepted
        @(negedge clock);
        step();
        step();
        step();
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        check_idle_after_reset("reset");
        chk("reset_addr1", bus.addr1, 3'd0);
        chk("reset_addr2", bus.addr2, 3'd0);
        for (int i = 0; i < 5; i++) step();

        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h05);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h03);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
        drain();
        chk("t1_r3", u_rf.r_mem[3], 8'h08);

        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'hFF);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h01);
        issue(OP_ADD, 3'd1, 3'd2, 3'd4, 8'h00);
        drain();
        chk("t2_result", bus.result, 8'h00);
        chk("t2_flag_z", bus.flag_z, 1'b1);
        chk("t2_flag_c", bus.flag_c, 1'b1);

        issue(OP_SUB, 3'd2, 3'd1, 3'd5, 8'h00);
        drain();
        chk("t3_r5", u_rf.r_mem[5], 8'h02);
        chk("t3_flag_c", bus.flag_c, 1'b1);

        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h05);
        issue(OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00);
        issue(OP_SHL1, 3'd1, 3'd0, 3'd6, 8'h00);
        drain();
        chk("t4_r1", u_rf.r_mem[1], 8'h0A);
        chk("t4_r6", u_rf.r_mem[6], 8'h14);

        issue(OP_XOR, 3'd6, 3'd2, 3'd7, 8'h00);
        issue(OP_AND, 3'd6, 3'd2, 3'd0, 8'h00);
        issue(OP_OR, 3'd6, 3'd2, 3'd0, 8'h00);
        issue(OP_SHR1, 3'd2, 3'd0, 3'd7, 8'h00);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h80);
        issue(OP_SHL1, 3'd2, 3'd0, 3'd7, 8'h00);
        drain();

        // valid held for 10 cycles: acceptances only on cycles 0, 4 and 8
        acc0 = n_acc;
        bus.cmd_op = OP_ADD;
        bus.cmd_src1 = 3'd1;
        bus.cmd_src2 = 3'd1;
        bus.cmd_dst = 3'd1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_ready_%0d", i), bus.cmd_ready, (i % 4) == 0);
            step();
        end
        bus.cmd_valid = 1'b0;
        chk("hold_accepts", n_acc - acc0, 3);
        drain();
        chk("hold_r1", u_rf.r_mem[1], 8'h50);

        abort_in(1, "abort_exec");
        abort_in(2, "abort_write");

        issue(OP_OR, 3'd3, 3'd3, 3'd0, 8'h00);
        drain();
        chk("final_r0", u_rf.r_mem[0], 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 SHALL have parameter N, default 8: data word width, equal to the register-file word width.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-006 SHALL have port cmd_op, input, 3 bits: operation code.
REQ-007 SHALL have ports cmd_src1, cmd_src2 and cmd_dst, inputs, 3 bits each: operand A, operand B and destination register indices.
REQ-008 SHALL have port cmd_imm, input, N bits: immediate value for LDI.
REQ-009 SHALL have ports addr1 and addr2, outputs, 3 bits each: register-file read addresses.
REQ-010 SHALL have ports z1 and z2, inputs, N bits each: combinational register-file read data for addr1 and addr2.
REQ-011 SHALL have port addr3, output, 3 bits: register-file write address.
REQ-012 SHALL have port wr_data, output, N bits: write data, connected to the register-file data input.
REQ-013 SHALL have port wr_en, output, 1 bit: register-file write enable.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have ports result, output, N bits, and flag_z and flag_c, outputs, 1 bit each: last result and its flags, held until the next completion.

Function
REQ-016 SHALL implement FSM states IDLE, READ, EXEC and WRITE.
REQ-017 SHALL drive cmd_ready=1 only in IDLE, and SHALL accept a command on a cycle where cmd_valid&cmd_ready=1.
REQ-018 SHALL latch op, src1, src2, dst and imm on acceptance, and SHALL go IDLE->READ.
REQ-019 SHALL, in READ, drive addr1=src1 and addr2=src2, capture z1 and z2 into operand registers A and B at the clock edge, and go to EXEC.
REQ-020 SHALL, in EXEC, compute the result into a result register and go to WRITE.
REQ-021 SHALL, in WRITE, drive wr_en=1, addr3=dst, wr_data=result register and done=1 for exactly one cycle, update result, flag_z and flag_c at that edge, and go to IDLE.
REQ-022 SHALL have a latency of 3 cycles from the acceptance edge to the write edge, and a throughput of one command per 4 cycles.
REQ-023 SHALL implement op codes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SHL1 A<<1 (zero fill); 6 SHR1 A>>1 (zero fill); 7 LDI, result=imm, operands ignored.
REQ-024 SHALL compute all arithmetic modulo 2^N.
REQ-025 SHALL set flag_c to the carry-out for ADD, to the borrow (A<B unsigned) for SUB, to the bit shifted out for SHL1 and SHR1, and to 0 otherwise.
REQ-026 SHALL set flag_z=1 iff the result equals 0.
REQ-027 SHALL drive wr_en=0 and done=0 in every state except WRITE, and SHALL drive addr1, addr2 and addr3 from the latched fields in all states.
REQ-028 SHALL make a command whose src equals the previous command's dst read the new value, because the write completes at the WRITE edge before the next READ.
REQ-029 SHALL allow src1=src2=dst, with operands read before the write.
REQ-030 SHALL ignore cmd_valid outside IDLE; the command SHALL be held until accepted.

Reset
REQ-031 SHALL, while reset=1 at a posedge, set state=IDLE, all latched fields, operands and result to 0, flag_z=0 and flag_c=0, and hold wr_en=0 and done=0.
REQ-032 SHALL make reset take priority over a handshake in the same cycle; that command SHALL NOT be accepted.
REQ-033 SHALL abort any in-flight command on reset with no register-file write, including when reset is asserted in WRITE: wr_en SHALL be forced 0 combinationally while reset=1.

Structure
REQ-034 SHALL take the op-code constants (OP_ADD..OP_LDI) and the FSM state encoding from a shared package, rf_pkg.
REQ-035 SHALL use one sub-module, rf_alu: combinational, inputs op, A, B and imm; outputs result and carry.
REQ-036 SHALL be verified with the bench instantiating the existing 8-entry register file (two combinational read ports, one clocked enabled write port) connected to this block.

Verification
REQ-037 SHALL cover LDI r1<-0x05, then LDI r2<-0x03, then ADD r3=r1+r2 -> wr_data=0x08 at addr3=3, done pulse, flag_z=0, flag_c=0, 3 cycles after acceptance.
REQ-038 SHALL cover r1=0xFF, r2=0x01, ADD r4 -> result=0x00, flag_z=1, flag_c=1.
REQ-039 SHALL cover SUB r5=r2-r1 with r2=0x01, r1=0xFF -> result=0x02, flag_c=1.
REQ-040 SHALL cover ADD r1=r1+r1 (r1=0x05) followed by SHL1 r6=r1 -> first write 0x0A, second write 0x14 (read-after-write), flag_c=0.
REQ-041 SHALL cover cmd_valid held high for 10 cycles -> exactly 3 acceptances (cycles 0, 4, 8), cmd_ready low in between.
REQ-042 SHALL cover reset asserted in EXEC and separately in WRITE -> no write (target register unchanged), state IDLE, cmd_ready=1 on the cycle after reset deasserts, outputs 0.
